cvxif_mac_nlane_pipe: RTL and testbench
=======================================

Name: cvxif_mac_nlane_pipe

Overview:
Parametrised successor to the single-cycle 4x8-bit MAC coprocessor datapath. It computes N-lane packed dot products, either unsigned or signed, and can fold them into a persistent accumulator. The datapath is a 2-stage pipeline feeding an in-order result FIFO with backpressure. The block sits behind the CV-X-IF decoder: the decoder supplies accepted instructions on the issue side, and the result side drives the CV-X-IF result channel.

Parameters:
XLEN, 32, operand/result width in bits
EW, 8, element width in bits; LANES = XLEN/EW (elaboration error if XLEN % EW != 0)
FIFO_DEPTH, 4, result FIFO entries (>=2, power of 2)
ID_W, 3, instruction id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
in_valid_i  in  1  instruction offered
in_ready_o  out  1  instruction can be accepted
in_id_i  in  ID_W  instruction id
in_rd_i  in  5  destination register
in_op_i  in  2  0=DOTU, 1=DOTS, 2=MACS, 3=ACCRD (read-and-clear)
in_rs1_i  in  XLEN  packed inputs, lane k = bits[k*EW +: EW]
in_rs2_i  in  XLEN  packed weights
flush_i  in  1  drop all in-flight and queued results
out_valid_o  out  1  result available
out_ready_i  in  1  consumer takes result
out_id_o  out  ID_W  result id
out_rd_o  out  5  result rd
out_data_o  out  XLEN  result data
out_we_o  out  1  write enable (1 whenever out_valid_o)
busy_o  out  1  any stage or FIFO entry valid

Behaviour:
- Reset (sync, rst_ni=0 at edge): S1/S2 valid=0, FIFO empty, acc=0. Outputs: out_valid_o=0, busy_o=0, in_ready_o=0 while rst_ni=0. out_data/id/rd=0 while empty.
- Accept: in_valid_i & in_ready_o at edge N → S1 registers the LANES products, op, id and rd. S2 at edge N+1 computes the sum, updates acc and writes the FIFO. out_valid_o is high in the cycle after edge N+1 (2-cycle latency) if the FIFO was empty. Sustained throughput is 1/cycle.
- Credit: in_ready_o = !flush_i & (fifo_count + S1.v + S2.v < FIFO_DEPTH), combinational. A FIFO pop in the same cycle is not counted, so there are no combinational paths from out_ready_i to in_ready_o.
- Products: DOTU zero-extends each EW element; DOTS and MACS sign-extend. Each product is 2*EW bits. The lane sum is extended to XLEN (sign-extended for signed ops) and truncated mod 2^XLEN.
- DOTU/DOTS: result = lane sum. acc is untouched.
- MACS: acc_next = acc + signed sum (mod 2^XLEN); result = acc_next. Back-to-back MACS chain correctly because acc is updated only in S2, in order.
- ACCRD: result = acc before the update; acc <= 0. ACCRD and MACS never coexist in S2 (one op per cycle).
- FIFO: in order. Pop on out_valid_o & out_ready_i. Push and pop in the same cycle on a full FIFO is legal, and the count is unchanged. Pointers wrap mod FIFO_DEPTH. Outputs are driven from the FIFO head. Once valid, out_* are held stable until popped.
- Flush (sync, at edge): clears S1/S2 valid and empties the FIFO. Flushed MACS/ACCRD ops do not modify acc; acc itself is preserved. in_ready_o=0 during flush, so there is no accept in that cycle. out_valid_o=0 in the next cycle.
- Reset asserted mid-operation overrides flush and everything in flight; all state returns to reset values at that edge.
- busy_o = S1.v | S2.v | (fifo_count != 0).

Test Plan:
- DOTU, rs1=0x04030201, rs2=0x01010101, id=5, rd=7 → two cycles later out_valid=1, data=0x0000000A, id=5, rd=7, we=1.
- rs1=0xFFFFFFFF, rs2=0x02020202: DOTS → 0xFFFFFFF8; DOTU → 0x000007F8.
- ACCRD, then 3 back-to-back MACS with rs1=rs2=0x01010101 → results 4, 8, 12. Then ACCRD → 12; following MACS → 4.
- out_ready_i=0, offer 6 DOTU ops (ids 0-5), FIFO_DEPTH=4 → exactly ids 0-3 accepted, in_ready_o=0 afterward, busy_o=1. Raise out_ready_i → results pop as 0,1,2,3, then ids 4,5 are accepted.
- Preload acc=4. Issue MACS (id=1, rs1=rs2=0x01010101), pulse flush_i one cycle later → no output for id 1. Next ACCRD returns 4.
- Mid-stream with 3 results queued, hold rst_ni=0 for one cycle → next cycle out_valid_o=0, busy_o=0. Subsequent ACCRD returns 0.

Source files
------------

// File: rtl/cvxif_mac_nlane_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cvxif_mac_nlane_pipe
//  Description : N-lane packed dot-product / MAC coprocessor datapath for the
//                CV-X-IF. The operand stage registers the per-lane products.
//                The sum stage reduces them, updates the accumulator and
//                pushes into an in-order result FIFO with credit-based
//                backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module cvxif_mac_nlane_pipe #(
    parameter int XLEN       = 32,
    parameter int EW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [ID_W-1:0] in_id_i,
    input  logic [4:0]      in_rd_i,
    input  logic [1:0]      in_op_i,
    input  logic [XLEN-1:0] in_rs1_i,
    input  logic [XLEN-1:0] in_rs2_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [ID_W-1:0] out_id_o,
    output logic [4:0]      out_rd_o,
    output logic [XLEN-1:0] out_data_o,
    output logic            out_we_o,
    output logic            busy_o
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int LANES   = XLEN / EW;
    localparam int PEW     = 2 * EW;                 // product width per lane
    localparam int PW      = $clog2(FIFO_DEPTH);     // FIFO pointer width
    localparam int CW      = PW + 1;                 // FIFO count width (holds DEPTH)
    localparam int ENTRY_W = ID_W + 5 + XLEN;        // {id, rd, data}

    localparam logic [1:0] OP_DOTU  = 2'd0;
    localparam logic [1:0] OP_DOTS  = 2'd1;
    localparam logic [1:0] OP_MACS  = 2'd2;
    localparam logic [1:0] OP_ACCRD = 2'd3;

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    generate
        if ((XLEN % EW) != 0) begin : g_bad_ew
            $error("cvxif_mac_nlane_pipe: XLEN must be a multiple of EW");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("cvxif_mac_nlane_pipe: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Issue handshake
    // ------------------------------------------------------------------
    logic            accept;
    logic            in_signed;
    logic [CW:0]     inflight;
    logic [CW-1:0]   fifo_count;
    logic            s1_v;

    // Credit counts what is already committed to the FIFO: queued entries
    // plus the op sitting in the operand stage. A pop in the same cycle is
    // deliberately ignored so out_ready_i never reaches in_ready_o.
    assign inflight   = {1'b0, fifo_count} + (CW + 1)'(s1_v);
    assign in_ready_o = rst_ni & ~flush_i & (inflight < (CW + 1)'(FIFO_DEPTH));
    assign accept     = in_valid_i & in_ready_o;
    assign in_signed  = (in_op_i != OP_DOTU);

    // ------------------------------------------------------------------
    // Per-lane products (extended to 2*EW, so the low 2*EW bits of the
    // product are exact for both signed and unsigned elements)
    // ------------------------------------------------------------------
    logic [LANES*PEW-1:0] prod_in;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [PEW-1:0] a_ext;
            logic [PEW-1:0] b_ext;
            assign a_ext = {{EW{in_signed & in_rs1_i[k*EW + EW - 1]}}, in_rs1_i[k*EW +: EW]};
            assign b_ext = {{EW{in_signed & in_rs2_i[k*EW + EW - 1]}}, in_rs2_i[k*EW +: EW]};
            assign prod_in[k*PEW +: PEW] = a_ext * b_ext;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand stage (S1)
    // ------------------------------------------------------------------
    logic [1:0]           s1_op;
    logic [ID_W-1:0]      s1_id;
    logic [4:0]           s1_rd;
    logic [LANES*PEW-1:0] s1_prod;

    // Valid bit: reset and flush both drop the op held in S1.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_v <= 1'b0;
        end else if (flush_i) begin
            s1_v <= 1'b0;
        end else begin
            s1_v <= accept;
        end
    end

    // Payload: captured only on an accepted instruction.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_op   <= OP_DOTU;
            s1_id   <= '0;
            s1_rd   <= '0;
            s1_prod <= '0;
        end else if (accept) begin
            s1_op   <= in_op_i;
            s1_id   <= in_id_i;
            s1_rd   <= in_rd_i;
            s1_prod <= prod_in;
        end
    end

    // ------------------------------------------------------------------
    // Sum stage (S2): combinational on S1, commits at the following edge
    // straight into the accumulator and the FIFO, so its occupancy is the
    // S1 valid bit and it is already counted in the credit above.
    // ------------------------------------------------------------------
    logic            s1_signed;
    logic [XLEN-1:0] prod_ext [LANES];
    logic [XLEN-1:0] lane_sum;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [XLEN-1:0] result;

    assign s1_signed = (s1_op != OP_DOTU);

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_ext
            logic [PEW-1:0] p;
            assign p = s1_prod[k*PEW +: PEW];
            if (PEW < XLEN) begin : g_widen
                assign prod_ext[k] = {{(XLEN - PEW){s1_signed & p[PEW-1]}}, p};
            end else if (PEW == XLEN) begin : g_same
                assign prod_ext[k] = p;
            end else begin : g_trunc
                assign prod_ext[k] = p[XLEN-1:0];
            end
        end
    endgenerate

    // Reduce the extended lane products modulo 2^XLEN.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + prod_ext[k];
        end
    end

    // Result selection and accumulator next value per opcode.
    always_comb begin
        result   = lane_sum;
        acc_next = acc;
        case (s1_op)
            OP_MACS: begin
                acc_next = acc + lane_sum;
                result   = acc + lane_sum;
            end
            OP_ACCRD: begin
                acc_next = '0;
                result   = acc;
            end
            default: begin
                result   = lane_sum;
                acc_next = acc;
            end
        endcase
    end

    // Accumulator: updated in program order by S2; flushed ops leave it alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc <= '0;
        end else if (s1_v && !flush_i) begin
            acc <= acc_next;
        end
    end

    // ------------------------------------------------------------------
    // In-order result FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // The credit check guarantees there is room whenever S1 is valid.
    assign push = s1_v & ~flush_i;
    assign pop  = (fifo_count != '0) & out_ready_i;

    // Storage: written at the tail, no reset needed since reads are gated.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s1_id, s1_rd, result};
        end
    end

    // Pointers and occupancy; flush and reset empty the queue.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result channel, driven from the FIFO head and zeroed while empty
    // ------------------------------------------------------------------
    assign head        = fifo_mem[rd_ptr];
    assign out_valid_o = (fifo_count != '0);
    assign out_we_o    = out_valid_o;
    assign out_id_o    = out_valid_o ? head[ENTRY_W-1 -: ID_W] : '0;
    assign out_rd_o    = out_valid_o ? head[XLEN +: 5]         : '0;
    assign out_data_o  = out_valid_o ? head[XLEN-1:0]          : '0;
    assign busy_o      = s1_v | out_valid_o;

endmodule
`default_nettype wire

// File: tb/tb_cvxif_mac_nlane_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cvxif_mac_nlane_pipe
//  Description : Directed, table-driven self-checking bench for
//                cvxif_mac_nlane_pipe (XLEN=32, EW=8, FIFO_DEPTH=4, ID_W=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cvxif_mac_nlane_pipe;

    localparam logic [1:0] OP_DOTU  = 2'd0;
    localparam logic [1:0] OP_DOTS  = 2'd1;
    localparam logic [1:0] OP_MACS  = 2'd2;
    localparam logic [1:0] OP_ACCRD = 2'd3;

    logic        clk;
    logic        rst_ni;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_id;
    logic [4:0]  in_rd;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_id;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_we;
    logic        busy;

    int errors = 0;
    int checks = 0;

    cvxif_mac_nlane_pipe #(
        .XLEN(32), .EW(8), .FIFO_DEPTH(4), .ID_W(3)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_id_i    (in_id),
        .in_rd_i    (in_rd),
        .in_op_i    (in_op),
        .in_rs1_i   (in_rs1),
        .in_rs2_i   (in_rs2),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_id_o   (out_id),
        .out_rd_o   (out_rd),
        .out_data_o (out_data),
        .out_we_o   (out_we),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  id;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one instruction and hold it until accepted (bounded wait).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] id, input logic [4:0] rd);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_id    = id;
        in_rd    = rd;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Issue into an empty pipe, check 2-cycle latency and the result, then pop.
    task automatic run_expect(input string name, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [2:0] id, input logic [4:0] rd,
                              input logic [31:0] exp);
        issue(op, a, b, id, rd);
        chk({name, "_early_valid"}, 64'(out_valid), 64'd0);
        tick();
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"},  64'(out_data),  64'(exp));
        chk({name, "_id"},    64'(out_id),    64'(id));
        chk({name, "_rd"},    64'(out_rd),    64'(rd));
        chk({name, "_we"},    64'(out_we),    64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_idle"},  64'(busy),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int next_id;
        int popped;
        bit take;
        bit first;

        vecs[0]  = '{OP_DOTU,  32'h04030201, 32'h01010101, 3'd5, 5'd7,  32'h0000000A};
        vecs[1]  = '{OP_DOTS,  32'hFFFFFFFF, 32'h02020202, 3'd1, 5'd1,  32'hFFFFFFF8};
        vecs[2]  = '{OP_DOTU,  32'hFFFFFFFF, 32'h02020202, 3'd2, 5'd2,  32'h000007F8};
        vecs[3]  = '{OP_ACCRD, 32'h00000000, 32'h00000000, 3'd3, 5'd3,  32'h00000000};
        vecs[4]  = '{OP_MACS,  32'h01010101, 32'h01010101, 3'd4, 5'd4,  32'h00000004};
        vecs[5]  = '{OP_MACS,  32'h01010101, 32'h01010101, 3'd5, 5'd5,  32'h00000008};
        vecs[6]  = '{OP_MACS,  32'h01010101, 32'h01010101, 3'd6, 5'd6,  32'h0000000C};
        vecs[7]  = '{OP_ACCRD, 32'h00000000, 32'h00000000, 3'd7, 5'd8,  32'h0000000C};
        vecs[8]  = '{OP_MACS,  32'h01010101, 32'h01010101, 3'd0, 5'd9,  32'h00000004};
        vecs[9]  = '{OP_DOTS,  32'h7F7F7F7F, 32'h80808080, 3'd1, 5'd10, 32'hFFFF0200};
        vecs[10] = '{OP_DOTU,  32'h7F7F7F7F, 32'h80808080, 3'd2, 5'd11, 32'h0000FE00};
        vecs[11] = '{OP_DOTS,  32'h01FF0280, 32'h03030303, 3'd3, 5'd31, 32'hFFFFFE86};

        rst_ni    = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_DOTU;
        in_rs1    = 32'h0;
        in_rs2    = 32'h0;
        in_id     = 3'd0;
        in_rd     = 5'd0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready),  64'd0);
        chk("rst_valid",    64'(out_valid), 64'd0);
        chk("rst_busy",     64'(busy),      64'd0);
        chk("rst_data",     64'(out_data),  64'd0);
        chk("rst_id",       64'(out_id),    64'd0);
        in_valid = 1'b0;
        rst_ni   = 1'b1;
        tick();
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Table-driven single operations
        for (int i = 0; i < 12; i++) begin
            run_expect($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].rs2,
                       vecs[i].id, vecs[i].rd, vecs[i].exp);
        end

        // Backpressure: consumer stalled, six DOTU ops offered (data = id+1)
        out_ready = 1'b0;
        next_id   = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (next_id < 6);
            in_op    = OP_DOTU;
            in_id    = 3'(next_id);
            in_rd    = 5'(next_id);
            in_rs1   = 32'(next_id + 1);
            in_rs2   = 32'h01010101;
            #1;
            take = in_valid && in_ready;
            tick();
            if (take) next_id++;
        end
        chk("bp_accepted",  64'(next_id),  64'd4);
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        chk("bp_busy",      64'(busy),     64'd1);
        chk("bp_head_id",   64'(out_id),   64'd0);

        out_ready = 1'b1;
        popped    = 0;
        first     = 1'b1;
        for (int c = 0; c < 30 && popped < 6; c++) begin
            in_valid = (next_id < 6);
            in_op    = OP_DOTU;
            in_id    = 3'(next_id);
            in_rd    = 5'(next_id);
            in_rs1   = 32'(next_id + 1);
            in_rs2   = 32'h01010101;
            #1;
            if (first) begin
                chk("bp_no_pop_credit", 64'(in_ready), 64'd0);
                first = 1'b0;
            end
            if (out_valid) begin
                chk($sformatf("bp_pop%0d_id", popped),   64'(out_id),   64'(popped));
                chk($sformatf("bp_pop%0d_data", popped), 64'(out_data), 64'(popped + 1));
                popped++;
            end
            take = in_valid && in_ready;
            tick();
            if (take) next_id++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_popped",   64'(popped),  64'd6);
        chk("bp_all_in",   64'(next_id), 64'd6);
        chk("bp_idle",     64'(busy),    64'd0);

        // Flush: a MACS in flight must not reach the FIFO or the accumulator
        run_expect("fl_clr",  OP_ACCRD, 32'h0, 32'h0, 3'd0, 5'd1, 32'h00000004);
        run_expect("fl_load", OP_MACS, 32'h01010101, 32'h01010101, 3'd2, 5'd2, 32'h00000004);
        issue(OP_MACS, 32'h01010101, 32'h01010101, 3'd1, 5'd3);
        flush = 1'b1;
        #1;
        chk("fl_ready_low", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_busy",  64'(busy),      64'd0);
        tick();
        tick();
        chk("fl_still_empty", 64'(out_valid), 64'd0);
        run_expect("fl_acc", OP_ACCRD, 32'h0, 32'h0, 3'd4, 5'd4, 32'h00000004);

        // Reset mid-stream with three results queued
        run_expect("rs_load", OP_MACS, 32'h01010101, 32'h01010101, 3'd5, 5'd5, 32'h00000004);
        out_ready = 1'b0;
        issue(OP_DOTU, 32'h00000001, 32'h00000001, 3'd2, 5'd2);
        issue(OP_DOTU, 32'h00000002, 32'h00000001, 3'd3, 5'd3);
        issue(OP_DOTU, 32'h00000003, 32'h00000001, 3'd4, 5'd4);
        tick();
        chk("rs_queued_valid", 64'(out_valid), 64'd1);
        chk("rs_queued_head",  64'(out_data),  64'd1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("rs_valid", 64'(out_valid), 64'd0);
        chk("rs_busy",  64'(busy),      64'd0);
        chk("rs_data",  64'(out_data),  64'd0);
        run_expect("rs_acc", OP_ACCRD, 32'h0, 32'h0, 3'd6, 5'd6, 32'h00000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
